// File: rtl/cache_pkg.sv
// Shared definitions for the cache memory-side stage: bus/line geometry,
// FSM state encoding and line-address helper.
package cache_pkg;

    localparam int ADDR_W           = 32;
    localparam int LINE_W           = 512;
    localparam int WORD_W           = 32;
    localparam int BEATS            = LINE_W / WORD_W;
    localparam int LINE_OFFSET_BITS = 6;
    localparam int CNT_W            = $clog2(BEATS);

    // Byte-offset bits inside one line; cleared to form the line base.
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << LINE_OFFSET_BITS) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    // Align a byte address down to the start of its cache line.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return addr & ~OFFSET_MASK;
    endfunction

endpackage

// File: rtl/line_fill_ctrl_buf.sv
// line_shift_buf: one cache line of storage with either a whole-line load
// (victim capture) or a single-word write by index (fill assembly).
// o_line_next exposes the contents as they will be after this cycle, so a
// caller can read a just-loaded line or a just-completed fill without
// waiting an extra cycle.
module line_shift_buf
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load_line,
    input  logic [LINE_W-1:0] i_line,
    input  logic              i_word_we,
    input  logic [CNT_W-1:0]  i_word_idx,
    input  logic [WORD_W-1:0] i_word,
    output logic [LINE_W-1:0] o_line_next
);

    logic [LINE_W-1:0] r_line;

    // Next buffer contents: a whole-line load takes priority over a word write.
    always_comb begin
        // NOTE: assign the default first so every path drives the output; a missing else would infer a latch.
        o_line_next = r_line;
        if (i_load_line) begin
            o_line_next = i_line;
        end else if (i_word_we) begin
            o_line_next[i_word_idx*WORD_W +: WORD_W] = i_word;
        end
    end

    // Line storage register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the line store is ordinary flops, so it takes the async reset too; no stale victim or fill survives a reset.
        if (!rst) begin
            r_line <= '0;
        end else begin
            r_line <= o_line_next;
        end
    end

endmodule

// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: on a cache miss, writes back an optional dirty victim line
// and then fetches the missing line over a 32-bit req/ack word bus, 16 beats
// per line, returning the assembled line with a one-cycle valid pulse.
module line_fill_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_req,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [LINE_W-1:0] wb_data,
    output logic [LINE_W-1:0] fill_data,
    output logic              fill_valid,
    output logic              wb_done,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_t            r_state, w_nxt_state;
    logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
    logic [ADDR_W-1:0] r_cur_base, w_nxt_base;
    logic [ADDR_W-1:0] r_fill_base, w_nxt_fill_base;
    logic              w_beat_done, w_last;
    logic              w_load_wb, w_fill_we;
    logic              w_wb_finish, w_fill_finish;
    logic              w_nxt_active;
    logic [LINE_W-1:0] w_wb_line, w_fill_line;
    logic [WORD_W-1:0] w_wb_word;

    // A beat completes only when a request is outstanding; stray acks are ignored.
    assign w_beat_done  = mem_req && mem_ack;
    assign w_last       = (r_cnt == CNT_W'(BEATS - 1));
    assign w_nxt_active = (w_nxt_state == WB) || (w_nxt_state == FILL);
    assign busy         = (r_state != IDLE);

    // Victim line captured in IDLE, serialised word by word during WB.
    line_shift_buf u_wb_buf (
        .clk         (clk),
        .rst         (rst),
        .i_load_line (w_load_wb),
        .i_line      (wb_data),
        .i_word_we   (1'b0),
        .i_word_idx  (w_nxt_cnt),
        .i_word      ('0),
        .o_line_next (w_wb_line)
    );

    // Word presented on the bus for the beat that starts next cycle.
    assign w_wb_word = w_wb_line[w_nxt_cnt*WORD_W +: WORD_W];

    // Fill line assembled from read beats in beat order.
    line_shift_buf u_fill_buf (
        .clk         (clk),
        .rst         (rst),
        .i_load_line (1'b0),
        .i_line      ('0),
        .i_word_we   (w_fill_we),
        .i_word_idx  (r_cnt),
        .i_word      (mem_rdata),
        .o_line_next (w_fill_line)
    );

    // Next-state, beat counter and line-base selection.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cnt       = r_cnt;
        w_nxt_base      = r_cur_base;
        w_nxt_fill_base = r_fill_base;
        w_load_wb       = 1'b0;
        w_fill_we       = 1'b0;
        w_wb_finish     = 1'b0;
        w_fill_finish   = 1'b0;
        case (r_state)
            IDLE: begin
                if (wb_req) begin
                    w_nxt_state     = WB;
                    w_nxt_cnt       = '0;
                    w_nxt_base      = line_base(wb_addr);
                    w_nxt_fill_base = line_base(fill_addr);
                    w_load_wb       = 1'b1;
                end else if (fill_req) begin
                    w_nxt_state     = FILL;
                    w_nxt_cnt       = '0;
                    w_nxt_base      = line_base(fill_addr);
                    w_nxt_fill_base = line_base(fill_addr);
                end
            end
            WB: begin
                if (w_beat_done) begin
                    if (w_last) begin
                        w_nxt_state = FILL;
                        w_nxt_cnt   = '0;
                        w_nxt_base  = r_fill_base;
                        w_wb_finish = 1'b1;
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
            end
            FILL: begin
                if (w_beat_done) begin
                    w_fill_we = 1'b1;
                    if (w_last) begin
                        w_nxt_state   = DONE;
                        w_nxt_cnt     = '0;
                        w_fill_finish = 1'b1;
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
            end
            DONE:    w_nxt_state = IDLE;
            default: w_nxt_state = IDLE;
        endcase
    end

    // State, counter and latched line bases.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cur_base  <= '0;
            r_fill_base <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_cur_base  <= w_nxt_base;
            r_fill_base <= w_nxt_fill_base;
        end
    end

    // Registered bus and completion outputs, computed from the next beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wb_done    <= 1'b0;
            fill_valid <= 1'b0;
            fill_data  <= '0;
        end else begin
            mem_req    <= w_nxt_active;
            mem_we     <= (w_nxt_state == WB);
            mem_addr   <= w_nxt_active ? (w_nxt_base | ADDR_W'({w_nxt_cnt, 2'b00})) : '0;
            mem_wdata  <= (w_nxt_state == WB) ? w_wb_word : '0;
            wb_done    <= w_wb_finish;
            fill_valid <= w_fill_finish;
            if (w_fill_finish) begin
                fill_data <= w_fill_line;
            end
        end
    end

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Self-checking bench for line_fill_ctrl: a randomised word-bus memory with
// variable ack latency plus a transaction-level model of the expected beat
// sequence, write data and assembled fill line.
module tb_line_fill_ctrl;

    localparam int LINE_W = 512;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;
    localparam int BEATS  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              fill_req;
    logic [ADDR_W-1:0] fill_addr;
    logic              wb_req;
    logic [ADDR_W-1:0] wb_addr;
    logic [LINE_W-1:0] wb_data;
    logic [LINE_W-1:0] fill_data;
    logic              fill_valid;
    logic              wb_done;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    line_fill_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .wb_req     (wb_req),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .fill_data  (fill_data),
        .fill_valid (fill_valid),
        .wb_done    (wb_done),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } beat_t;

    beat_t beats[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory behaviour knobs and monitor bookkeeping.
    int          lat_mode  = 0;   // 0: ack every cycle, 1: every 3rd cycle of a beat, 2: random 1..4
    bit          spur      = 0;   // random acks while no request is outstanding
    bit          seq_rdata = 0;   // read data = 0x1000 + read-beat index
    int          wait_cnt  = 0;
    int          cur_lat   = 1;
    int          req_cycles, fv_cnt, wbd_cnt, rd_idx;
    bit          waiting   = 0;
    logic [31:0] hold_addr, hold_wdata;
    logic        hold_we;
    logic [LINE_W-1:0] fv_line;

    // Reference transaction.
    bit                m_wb;
    logic [31:0]       m_wbase, m_fbase;
    logic [LINE_W-1:0] m_wdata;

    function automatic int pick_lat();
        case (lat_mode)
            0:       return 1;
            1:       return 3;
            default: return int'($urandom_range(1, 4));
        endcase
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < BEATS; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // Memory responder and output monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            mem_ack  = 1'b0;
            waiting  = 0;
            wait_cnt = 0;
        end else begin
            if (fill_valid) begin
                fv_cnt++;
                fv_line = fill_data;
            end
            if (wb_done) wbd_cnt++;
            if (mem_req) begin
                req_cycles++;
                if (waiting) begin
                    check("hold_addr", mem_addr, hold_addr);
                    check("hold_we", mem_we, hold_we);
                    check("hold_wdata", mem_wdata, hold_wdata);
                end
                wait_cnt++;
                if (wait_cnt >= cur_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = seq_rdata ? 32'h1000 + 32'(rd_idx) : $urandom;
                    if (!mem_we) rd_idx++;
                    beats.push_back(beat_t'{mem_we, mem_addr, mem_wdata, mem_rdata});
                    wait_cnt = 0;
                    cur_lat  = pick_lat();
                    waiting  = 0;
                end else begin
                    mem_ack    = 1'b0;
                    mem_rdata  = $urandom;
                    waiting    = 1;
                    hold_addr  = mem_addr;
                    hold_we    = mem_we;
                    hold_wdata = mem_wdata;
                end
            end else begin
                mem_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata = $urandom;
                waiting   = 0;
            end
        end
    end

    task automatic setup_model(input bit wb, input logic [31:0] waddr,
                               input logic [LINE_W-1:0] wd, input logic [31:0] faddr);
        beats.delete();
        fv_cnt     = 0;
        wbd_cnt    = 0;
        req_cycles = 0;
        rd_idx     = 0;
        wait_cnt   = 0;
        cur_lat    = pick_lat();
        m_wb       = wb;
        m_wbase    = waddr & ~32'h3F;
        m_fbase    = faddr & ~32'h3F;
        m_wdata    = wd;
    endtask

    task automatic start_txn(input bit wb, input logic [31:0] waddr,
                             input logic [LINE_W-1:0] wd, input logic [31:0] faddr);
        setup_model(wb, waddr, wd, faddr);
        wb_req    = wb;
        wb_addr   = waddr;
        wb_data   = wd;
        fill_addr = faddr;
        fill_req  = 1'b1;
    endtask

    // Runs until fill_valid; cyc counts cycles with the request cycle as cycle 1.
    task automatic finish_txn(input bit hold, output int cyc);
        cyc = 1;
        while (fv_cnt == 0 && cyc < 3000) begin
            @(negedge clk); #1;
            cyc++;
            if (cyc == 6) begin
                fill_addr = $urandom;
                wb_addr   = $urandom;
                wb_data   = rand_line();
            end
        end
        if (fv_cnt == 0) check("timeout", 0, 1);
        if (!hold) begin
            fill_req = 1'b0;
            wb_req   = 1'b0;
            @(negedge clk); #1;
            check("busy_after_done", busy, 0);
        end
    endtask

    task automatic check_txn();
        int                n_exp;
        int                off;
        logic [LINE_W-1:0] exp_line;
        n_exp    = m_wb ? 2 * BEATS : BEATS;
        off      = m_wb ? BEATS : 0;
        exp_line = '0;
        check("beat_count", beats.size(), n_exp);
        if (beats.size() == n_exp) begin
            for (int k = 0; k < BEATS; k++) begin
                if (m_wb) begin
                    check("wb_we", beats[k].we, 1);
                    check("wb_addr", beats[k].addr, m_wbase + 32'(4 * k));
                    check("wb_wdata", beats[k].wdata, m_wdata[32*k +: 32]);
                end
                check("rd_we", beats[off+k].we, 0);
                check("rd_addr", beats[off+k].addr, m_fbase + 32'(4 * k));
                exp_line[32*k +: 32] = beats[off+k].rdata;
            end
        end
        check("fill_data", fv_line, exp_line);
        check("fill_valid_cnt", fv_cnt, 1);
        check("wb_done_cnt", wbd_cnt, m_wb ? 1 : 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_fill_valid"}, fill_valid, 0);
        check({tag, "_wb_done"}, wb_done, 0);
        check({tag, "_fill_data"}, fill_data, 0);
    endtask

    initial begin
        int          cyc;
        int          guard;
        logic [31:0] next_base;

        rst       = 1'b0;
        fill_req  = 1'b0;
        fill_addr = '0;
        wb_req    = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk); #1;

        // Clean fill, ack every cycle, sequential read data.
        seq_rdata = 1;
        lat_mode  = 0;
        start_txn(0, '0, '0, 32'h0000_1004);
        finish_txn(0, cyc);
        check("fill_latency", cyc, 18);
        check_txn();
        for (int k = 0; k < BEATS; k++) check("clean_word", fv_line[32*k +: 32], 32'h1000 + 32'(k));
        seq_rdata = 0;

        // Write-back then fill.
        start_txn(1, 32'h0000_2000, {16{32'hDEAD_BEEF}}, 32'h0000_F000);
        finish_txn(0, cyc);
        check("wb_fill_latency", cyc, 34);
        check_txn();

        // Stalled memory: ack on the third cycle of every beat.
        lat_mode = 1;
        start_txn(1, 32'h0000_3040, rand_line(), 32'h0000_5000);
        finish_txn(0, cyc);
        check_txn();
        start_txn(0, '0, '0, 32'h0000_6010);
        finish_txn(0, cyc);
        check_txn();
        check("stall_req_cycles", req_cycles, 48);

        // Spurious acks while idle must not start anything.
        spur = 1;
        repeat (6) begin
            @(negedge clk); #1;
            check("spur_busy", busy, 0);
            check("spur_mem_req", mem_req, 0);
        end

        // Reset during beat 7 of a fill.
        lat_mode = 0;
        spur     = 0;
        start_txn(0, '0, '0, 32'h0000_4000);
        guard = 0;
        while (beats.size() < 7 && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        check("reach_beat7", beats.size(), 7);
        @(posedge clk); #1;
        check("beat7_addr", mem_addr, 32'h0000_401C);
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        fill_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("midreset_no_valid", fv_cnt, 0);
        check("midreset_idle", busy, 0);

        // Restarted fill begins again at beat 0.
        start_txn(0, '0, '0, 32'h0000_4000);
        finish_txn(0, cyc);
        check("restart_latency", cyc, 18);
        check_txn();

        // Back-to-back: fill_req held through fill_valid.
        start_txn(0, '0, '0, 32'h0000_8000);
        finish_txn(1, cyc);
        check_txn();
        @(negedge clk); #1;
        check("b2b_busy_gap", busy, 0);
        next_base = fill_addr & ~32'h3F;
        setup_model(0, '0, '0, fill_addr);
        @(negedge clk); #1;
        check("b2b_busy_again", busy, 1);
        check("b2b_mem_req", mem_req, 1);
        check("b2b_first_addr", mem_addr, next_base);
        finish_txn(0, cyc);
        check_txn();

        // Randomised traffic with random latency and stray acks.
        lat_mode = 2;
        spur     = 1;
        for (int t = 0; t < 10; t++) begin
            start_txn(1'($urandom_range(0, 1)), $urandom, rand_line(), $urandom);
            finish_txn(0, cyc);
            check_txn();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_fill_ctrl.md
Name: line_fill_ctrl

Overview:
- Memory-side stage directly downstream of the 4-way cache.
- On a miss, the cache raises ask_for_data. This block then writes back any dirty victim line and fetches the missing 512-bit line from main memory.
- Memory is reached over a 32-bit word bus using a req/ack handshake, 16 beats per line.
- It returns the assembled line to the cache with a one-cycle valid pulse.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 512, cache line width in bits
WORD_W, 32, memory bus word width
BEATS, LINE_W/WORD_W (16), beats per line transfer

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
fill_req  in  1  level; cache asks for a line (driven from ask_for_data)
fill_addr  in  ADDR_W  miss address; bits [5:0] are ignored
wb_req  in  1  level; dirty victim must be written back first
wb_addr  in  ADDR_W  victim line address; bits [5:0] are ignored
wb_data  in  LINE_W  victim line contents
fill_data  out  LINE_W  assembled line
fill_valid  out  1  one-cycle pulse: fill_data is valid
wb_done  out  1  one-cycle pulse: victim fully written
busy  out  1  high in every state except IDLE
mem_req  out  1  beat request
mem_we  out  1  1 = write beat, 0 = read beat
mem_addr  out  ADDR_W  word address of the current beat
mem_wdata  out  WORD_W  write word
mem_rdata  in  WORD_W  read word, valid when mem_ack=1
mem_ack  in  1  beat accepted or completed

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, beat counter=0.
  - fill_data=0, fill_valid=0, wb_done=0, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset asserted mid-transfer aborts the transfer with no completion pulse.
- States: IDLE, WB, FILL, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - wb_req=1 -> latch wb_addr&~63, wb_data, fill_addr&~63 -> WB. Write-back always precedes the fill.
  - Else fill_req=1 -> latch fill_addr&~63 -> FILL.
  - Else stay in IDLE.
- Beat handshake:
  - mem_req stays high with mem_addr, mem_we and mem_wdata stable until the cycle with mem_req&&mem_ack. That cycle completes the beat.
  - The next beat is presented in the following cycle; mem_req may remain high across beats.
  - mem_ack while mem_req=0 is ignored.
  - A beat can complete every cycle, so the minimum line time is 16 cycles.
- Beat layout:
  - Beat k uses mem_addr = line_base + 4*k, for k = 0..15.
  - Beat k carries word bits [32k+31:32k]; word 0 is the least-significant word.
- WB:
  - mem_we=1, mem_wdata = latched wb_data word k.
  - On completion of beat 15: wb_done pulses for 1 cycle, the counter clears, and the state goes to FILL in the next cycle.
  - The fill always follows a write-back.
- FILL:
  - mem_we=0.
  - On beat completion, mem_rdata is written into word k of the fill buffer.
  - After beat 15 -> DONE.
- DONE:
  - fill_valid=1 for exactly one cycle, then IDLE.
  - fill_data holds its value until the next fill completes.
- Counter: 4-bit, wraps 15->0 only at the end of a line.
- Request changes: changes to fill_req/wb_req or the addresses outside IDLE are ignored. A request still held high on return to IDLE starts a new transaction, so the cache must drop fill_req upon fill_valid.
- Output timing: all outputs are registered except busy, which is decoded from state.

Decomposition:
- Shared package (cache_pkg): ADDR_W, LINE_W, WORD_W, BEATS, the LINE_OFFSET_BITS=6 constant, and the state enum {IDLE, WB, FILL, DONE}.
- One natural sub-module: line_shift_buf. It is a 512-bit buffer with a word-indexed load/select, used for both the victim serialiser and the fill assembler.
- The FSM and counter live in the top module.

Test Plan:
- Clean fill:
  - Stimulus: fill_req=1, fill_addr=32'h0000_1004, wb_req=0; memory acks every cycle with rdata=32'h1000+k.
  - Required: mem_addr 0x1000..0x103C; 16 read beats; fill_valid pulses at cycle 18 after the request; fill_data word k = 0x1000+k.
- Write-back then fill:
  - Stimulus: wb_req=1, wb_addr=0x2000, wb_data=512'hDEAD_BEEF repeated; fill_addr=0xF000.
  - Required: 16 writes to 0x2000..0x203C with data DEADBEEF; wb_done pulses once; then 16 reads from 0xF000; one fill_valid.
- Stalled memory:
  - Stimulus: mem_ack high only every 3rd cycle.
  - Required: mem_addr and mem_wdata stay stable while waiting; no beat is skipped or duplicated; total of 48 request cycles per line.
- Reset mid-fill:
  - Stimulus: rst=0 during beat 7.
  - Required: all outputs go to 0 immediately; no fill_valid; a subsequent fill starts again at beat 0.
- Spurious and late inputs:
  - Stimulus: mem_ack while idle; fill_addr changed during FILL.
  - Required: no state change; the original address sequence is completed.
- Back-to-back requests:
  - Stimulus: fill_req held high through fill_valid.
  - Required: a second transaction starts in the IDLE cycle after DONE; busy drops for exactly 1 cycle.
